pc_gen: RTL
===========

Name: pc_gen

Overview:
Parametrised program-counter generator for the IF stage, successor to the fixed single-step PC.
- Produces the fetch address `pc` and the instruction-memory chip enable `ce`.
- Supports a configurable reset vector, address width and instruction size.
- Accepts control-flow redirects: a branch/jump from ID and a flush (exception/eret) from the control unit.
- Buffers a branch that arrives while IF is stalled, so it is never lost.

Parameters:
ADDR_W, 32, width of pc and all target addresses
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
INST_BYTES, 4, pc increment per sequential fetch; power of two, at least 1
STALL_W, 6, width of the stall bus from the control unit; bit 0 is the IF stall

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
ctrl_stall  in  STALL_W  stall vector; only bit 0 is used here
flush  in  1  redirect to flush_pc; highest priority, overrides stall
flush_pc  in  ADDR_W  flush/exception target
branch_flag  in  1  branch/jump taken this cycle
branch_target  in  ADDR_W  branch/jump target
pc  out  ADDR_W  fetch address, registered
ce  out  1  instruction memory enable, registered
redirect_pending  out  1  a buffered branch is waiting for the stall to clear, registered

Behaviour:
Fixed: one clock `clk`; reset `rst` is synchronous and active-high. All state updates on the rising edge of `clk`; every output is registered.

Reset and ce:
- Edge with rst=1: ce<=0, pc<=RESET_VECTOR, pending state cleared.
- Edge with rst=0: ce<=1.
- While ce=0 (the edge with rst=0 that sees the old ce=0): pc<=RESET_VECTOR and pending is cleared; flush and branch are ignored.
- So after rst deasserts, fetch address RESET_VECTOR is presented with ce=1 for at least one cycle. The first increment occurs on the second edge after release.

pc update when ce=1 and rst=0, first match wins:
1. flush=1: pc<=flush_pc; pending cleared. Applies even when ctrl_stall[0]=1.
2. ctrl_stall[0]=0 and branch_flag=1: pc<=branch_target; pending cleared. A new branch beats an older pending one.
3. ctrl_stall[0]=0 and pending=1: pc<=pending target; pending cleared.
4. ctrl_stall[0]=0: pc<=pc+INST_BYTES, modulo 2^ADDR_W. From all-ones aligned, pc wraps to 0.
5. ctrl_stall[0]=1: pc holds. If branch_flag=1, pending<=1 and the pending target<=branch_target. A later stalled branch overwrites the pending target.

Alignment and output:
- The low log2(INST_BYTES) bits of flush_pc, branch_target and the pending target are forced to 0 before loading.
- redirect_pending equals the pending valid register.

Reset mid-operation: an edge with rst=1 clears everything, including pending and an in-flight flush, regardless of other inputs.

Decomposition:
Shared defines file holds:
- STALL bus range and the STALL_ENABLE/STALL_DISABLE constants.
- CHIP_ENABLE/CHIP_DISABLE and RST_ENABLE.
- Default RESET_VECTOR and INST_BYTES.

One natural sub-module: pc_redirect_buf.
- Holds the pending valid bit and target.
- Inputs: capture, clear, target.
- Outputs: valid, target.

Test Plan:
1. Hold rst=1 for 2 cycles, then release with RESET_VECTOR=32'h0000_0000 -> ce=0 during reset; after release pc=0 with ce=1 for one cycle, then 4, 8, 12 on successive cycles.
2. From pc=0x10, pulse ctrl_stall[0] for 3 cycles -> pc stays 0x10 for 3 cycles, then 0x14.
3. branch_flag=1 with target 0x100 while stalled, stall held 2 more cycles -> redirect_pending=1 and pc held; on the first unstalled edge pc=0x100 and redirect_pending=0.
4. Pending branch to 0x100 exists, then stall clears in the same cycle as a new branch to 0x200 -> pc=0x200 and pending cleared.
5. Stall asserted, flush=1 with flush_pc=0x8000_0180 and branch_flag=1 -> pc=0x8000_0180 and pending=0.
6. With ADDR_W=16, pc=0xFFFC and no stall -> pc=0x0000. Also: rst=1 while pending=1 -> pc=RESET_VECTOR and redirect_pending=0 after the edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants for the IF-stage program-counter generator: stall bus layout,
// enable/reset encodings and the default reset vector / instruction size.
package pc_gen_pkg;

    localparam int   STALL_BUS_W   = 6;
    localparam int   STALL_IF_BIT  = 0;
    localparam logic STALL_ENABLE  = 1'b1;
    localparam logic STALL_DISABLE = 1'b0;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEFAULT_INST_BYTES   = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for a branch that arrived while IF was stalled.
// Clear wins over capture so a redirect consuming the entry cannot be re-armed.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic [ADDR_W-1:0] target_in,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] target_q, target_d;

    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d  = 1'b1;
            target_d = target_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid  = valid_q;
    assign target = target_q;

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: reset vector, sequential increment, flush and branch
// redirects, with a stalled branch parked in pc_redirect_buf until IF resumes.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
    parameter int                INST_BYTES   = DEFAULT_INST_BYTES,
    parameter int                STALL_W      = STALL_BUS_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] ctrl_stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_pc,
    input  logic               branch_flag,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending
);

    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INST_BYTES - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              stall_if;
    logic              buf_capture, buf_clear;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_target;
    logic              stall_unused;

    // Only the IF bit of the stall bus matters to this stage.
    assign stall_if     = (ctrl_stall[STALL_IF_BIT] == STALL_ENABLE);
    assign stall_unused = &ctrl_stall;

    always_comb begin
        pc_d        = pc_q;
        ce_d        = CHIP_ENABLE;
        buf_capture = 1'b0;
        buf_clear   = 1'b0;
        if (rst == RST_ENABLE) begin
            ce_d      = CHIP_DISABLE;
            pc_d      = RESET_VECTOR;
            buf_clear = 1'b1;
        end else if (ce_q == CHIP_DISABLE) begin
            // First cycle out of reset presents the reset vector; redirects are ignored.
            pc_d      = RESET_VECTOR;
            buf_clear = 1'b1;
        end else if (flush) begin
            pc_d      = flush_pc & ALIGN_MASK;
            buf_clear = 1'b1;
        end else if (!stall_if && branch_flag) begin
            pc_d      = branch_target & ALIGN_MASK;
            buf_clear = 1'b1;
        end else if (!stall_if && buf_valid) begin
            pc_d      = buf_target;
            buf_clear = 1'b1;
        end else if (!stall_if) begin
            pc_d = pc_q + PC_STEP;
        end else if (branch_flag) begin
            buf_capture = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_q <= RESET_VECTOR;
            ce_q <= CHIP_DISABLE;
        end else begin
            pc_q <= pc_d;
            ce_q <= ce_d;
        end
    end

    pc_redirect_buf #(
        .ADDR_W(ADDR_W)
    ) u_redirect_buf (
        .clk      (clk),
        .rst      (rst),
        .capture  (buf_capture),
        .clear    (buf_clear),
        .target_in(branch_target & ALIGN_MASK),
        .valid    (buf_valid),
        .target   (buf_target)
    );

    assign pc               = pc_q;
    assign ce               = ce_q;
    assign redirect_pending = buf_valid;

endmodule
